shake_squeeze_reader: RTL and testbench

- Host-side counterpart of the SHAKE wrapper. It launches one SHAKE job (init pulse plus held configuration), then acts as the receiver of the wrapper's squeeze stream (dout, addr_perip, valid).
- The squeeze stream has no backpressure and can repeat words. This block de-duplicates words by address, checks their ordering, buffers them in a FIFO and re-emits them as a 32-bit valid/ready stream.
- It sits between the SHAKE wrapper and downstream samplers and storage writers.

---
 rtl/shake_pkg.sv | 27 ++
 rtl/shake_squeeze_reader_fifo.sv | 48 ++++
 rtl/shake_squeeze_reader.sv | 179 +++++++++++++++++
 tb/tb_shake_squeeze_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// Shared SHAKE constants and types; also used by the SHAKE wrapper.
package shake_pkg;

    localparam int RATE_WORDS_128 = 42;
    localparam int RATE_WORDS_256 = 34;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        COLLECT = 3'd2,
        DRAIN   = 3'd3,
        FINISH  = 3'd4
    } shake_state_e;

    // Total squeezed words for a job; fits 16 bits for every legal squeeze_num.
    function automatic logic [15:0] expected_words(input logic mode, input logic [9:0] squeeze_num);
        logic [15:0] rate;
        rate = (mode == SHAKE256) ? 16'(RATE_WORDS_256) : 16'(RATE_WORDS_128);
        return {6'd0, squeeze_num} * rate;
    endfunction

endpackage

// File: rtl/shake_squeeze_reader_fifo.sv
// First-word-fall-through synchronous FIFO; head word visible while not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_wptr - r_rptr;
    assign o_empty   = (o_count == '0);
    assign o_full    = (o_count == DEPTH_L);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/shake_squeeze_reader.sv
// Launches one SHAKE job, de-duplicates the squeeze stream by word index and
// re-emits the words in order through a FWFT FIFO as a valid/ready stream.
module shake_squeeze_reader
    import shake_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cfg_mode,
    input  logic [7:0]  cfg_absorb_num,
    input  logic [7:0]  cfg_last_block_bytes,
    input  logic [9:0]  cfg_squeeze_num,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        seq_err,
    output logic        timeout,
    output logic [15:0] words_rcvd,
    output logic        shk_init,
    output logic        shk_mode,
    output logic [7:0]  shk_absorb_num,
    output logic [7:0]  shk_last_block_bytes,
    output logic [9:0]  shk_squeeze_num,
    input  logic [31:0] shk_dout,
    input  logic [31:0] shk_addr,
    input  logic        shk_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    shake_state_e     r_state;
    shake_state_e     w_next;
    logic [15:0]      r_words;
    logic [15:0]      r_expected;
    logic [WD_W-1:0]  r_wd;
    logic             r_overflow;
    logic             r_seq_err;
    logic             r_timeout;
    logic             r_mode;
    logic [7:0]       r_absorb_num;
    logic [7:0]       r_last_block_bytes;
    logic [9:0]       r_squeeze_num;

    logic [29:0]      w_idx;
    logic [29:0]      w_exp_idx;
    logic             w_collect;
    logic             w_hit;
    logic             w_ahead;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_count;
    logic             w_ovf;
    logic             w_launch;
    logic             w_wd_expire;
    logic [15:0]      w_words_nx;
    logic             w_unused;

    // Byte-offset bits carry no information for 32-bit words.
    assign w_unused   = ^shk_addr[1:0];

    assign w_idx      = shk_addr[31:2];
    assign w_exp_idx  = {14'd0, r_words};
    assign w_collect  = (r_state == COLLECT);
    assign w_hit      = w_collect && shk_valid && (w_idx == w_exp_idx);
    assign w_ahead    = w_collect && shk_valid && (w_idx > w_exp_idx);
    assign w_pop      = out_valid && out_ready;
    assign w_ovf      = w_hit && w_full && !w_pop;
    assign w_words_nx = r_words + 16'd1;
    assign w_launch   = (r_state == IDLE) && start;
    assign w_wd_expire = w_collect && !w_hit && (r_wd == WD_LAST);

    sync_fifo_fwft #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_hit),
        .i_din   (shk_dout),
        .i_pop   (w_pop),
        .o_dout  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_valid = !w_empty;

    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        done     = 1'b0;
        shk_init = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = (cfg_squeeze_num == '0) ? DRAIN : LAUNCH;
            end
            LAUNCH: begin
                shk_init = 1'b1;
                w_next   = COLLECT;
            end
            COLLECT: begin
                if (w_hit && (w_words_nx == r_expected)) w_next = DRAIN;
                else if (w_wd_expire)                    w_next = DRAIN;
            end
            DRAIN: begin
                if (w_count == '0) w_next = FINISH;
            end
            FINISH: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_words            <= '0;
            r_expected         <= '0;
            r_wd               <= '0;
            r_overflow         <= 1'b0;
            r_seq_err          <= 1'b0;
            r_timeout          <= 1'b0;
            r_mode             <= 1'b0;
            r_absorb_num       <= '0;
            r_last_block_bytes <= '0;
            r_squeeze_num      <= '0;
        end else if (w_launch) begin
            r_mode             <= cfg_mode;
            r_absorb_num       <= cfg_absorb_num;
            r_last_block_bytes <= cfg_last_block_bytes;
            r_squeeze_num      <= cfg_squeeze_num;
            r_expected         <= expected_words(cfg_mode, cfg_squeeze_num);
            r_words            <= '0;
            r_wd               <= '0;
            r_overflow         <= 1'b0;
            r_seq_err          <= 1'b0;
            r_timeout          <= 1'b0;
        end else if (w_collect) begin
            // Overflowed words still count so the job can terminate.
            if (w_hit) begin
                r_words <= w_words_nx;
                r_wd    <= '0;
            end else if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end else begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_ovf)   r_overflow <= 1'b1;
            if (w_ahead) r_seq_err  <= 1'b1;
        end
    end

    assign words_rcvd           = r_words;
    assign overflow             = r_overflow;
    assign seq_err              = r_seq_err;
    assign timeout              = r_timeout;
    assign shk_mode             = r_mode;
    assign shk_absorb_num       = r_absorb_num;
    assign shk_last_block_bytes = r_last_block_bytes;
    assign shk_squeeze_num      = r_squeeze_num;

endmodule

// File: tb/tb_shake_squeeze_reader.sv
// Directed bench for shake_squeeze_reader: dedup, backpressure, overflow,
// skipped index/watchdog, zero squeeze and mid-job reset.
module tb_shake_squeeze_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cfg_mode;
    logic [7:0]  cfg_absorb_num;
    logic [7:0]  cfg_last_block_bytes;
    logic [9:0]  cfg_squeeze_num;
    logic        busy, done, overflow, seq_err, timeout;
    logic [15:0] words_rcvd;
    logic        shk_init, shk_mode;
    logic [7:0]  shk_absorb_num, shk_last_block_bytes;
    logic [9:0]  shk_squeeze_num;
    logic [31:0] shk_dout, shk_addr;
    logic        shk_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int vec = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int init_cnt = 0;
    int done_dirty = 0;
    logic [31:0] q_out[$];

    always #5 clk = ~clk;

    shake_squeeze_reader #(.FIFO_DEPTH(64), .TIMEOUT_CYC(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode),
        .cfg_absorb_num(cfg_absorb_num), .cfg_last_block_bytes(cfg_last_block_bytes),
        .cfg_squeeze_num(cfg_squeeze_num), .busy(busy), .done(done),
        .overflow(overflow), .seq_err(seq_err), .timeout(timeout),
        .words_rcvd(words_rcvd), .shk_init(shk_init), .shk_mode(shk_mode),
        .shk_absorb_num(shk_absorb_num), .shk_last_block_bytes(shk_last_block_bytes),
        .shk_squeeze_num(shk_squeeze_num), .shk_dout(shk_dout), .shk_addr(shk_addr),
        .shk_valid(shk_valid), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Monitor samples on the falling edge; inputs change 1ns after rising edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) q_out.push_back(out_data);
            if (done) done_cnt++;
            if (done && out_valid) done_dirty++;
            if (shk_init) init_cnt++;
        end
    end

    function automatic logic [31:0] wdata(input int i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx);
        shk_valid = 1'b1;
        shk_addr  = 32'(idx) << 2;
        shk_dout  = wdata(idx);
        step();
        shk_valid = 1'b0;
    endtask

    // Drives start for one cycle; returns in the cycle after the start edge.
    task automatic start_job(input logic mode, input logic [7:0] ab, input logic [7:0] lb,
                             input logic [9:0] sq);
        cfg_mode = mode; cfg_absorb_num = ab; cfg_last_block_bytes = lb; cfg_squeeze_num = sq;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_mode = ~mode; cfg_absorb_num = 8'hEE; cfg_last_block_bytes = 8'hDD; cfg_squeeze_num = 10'h3FF;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        step(); step();
    endtask

    task automatic check_order(input string tag, input int n);
        int bad;
        bad = 0;
        check({tag, "_count"}, 32'(q_out.size()), 32'(n));
        for (int i = 0; i < q_out.size() && i < n; i++)
            if (q_out[i] !== wdata(i)) bad++;
        check({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    task automatic new_test();
        q_out.delete();
        done_cnt = 0;
        done_dirty = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_mode = 1'b1; cfg_absorb_num = 8'h11;
        cfg_last_block_bytes = 8'h22; cfg_squeeze_num = 10'd5;
        shk_dout = '0; shk_addr = '0; shk_valid = 1'b0; out_ready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_flags", {29'd0, overflow, seq_err, timeout}, 0);
        check("rst_words", 32'(words_rcvd), 0);
        check("rst_init", 32'(shk_init), 0);
        check("rst_cfg", {5'd0, shk_mode, shk_absorb_num, shk_last_block_bytes, shk_squeeze_num}, 0);
        check("rst_out", {out_data[30:0], out_valid}, 0);
        rst = 1'b0;
        step();

        // Dedup: SHAKE128 x2, index 41 repeated at the block boundary
        new_test();
        out_ready = 1'b1;
        start_job(1'b0, 8'h03, 8'h17, 10'd2);
        check("t1_launch_init", 32'(shk_init), 1);
        check("t1_busy", 32'(busy), 1);
        step();
        check("t1_init_once", 32'(shk_init), 0);
        check("t1_cfg_held", {5'd0, shk_mode, shk_absorb_num, shk_last_block_bytes, shk_squeeze_num},
              {5'd0, 1'b0, 8'h03, 8'h17, 10'd2});
        for (int i = 0; i < 84; i++) begin
            send(i);
            if (i == 41) begin
                send(41);
                send(41);
            end
        end
        wait_done(300);
        check_order("t1", 84);
        check("t1_words", 32'(words_rcvd), 84);
        check("t1_done_once", 32'(done_cnt), 1);
        check("t1_flags", {29'd0, overflow, seq_err, timeout}, 0);
        check("t1_idle", 32'(busy), 0);

        // Backpressure: SHAKE256 x1, consumer stalls until capture is complete
        new_test();
        out_ready = 1'b0;
        start_job(1'b1, 8'h01, 8'h08, 10'd1);
        step();
        for (int i = 0; i < 34; i++) begin
            if (i == 5) begin
                cfg_squeeze_num = 10'd7;
                start = 1'b1;
            end
            send(i);
            start = 1'b0;
        end
        step(); step();
        check("t2_start_ignored", 32'(shk_squeeze_num), 1);
        check("t2_words", 32'(words_rcvd), 34);
        check("t2_holding", {30'd0, out_valid, busy}, 32'd3);
        check("t2_no_done_yet", 32'(done_cnt), 0);
        out_ready = 1'b1;
        wait_done(200);
        check_order("t2", 34);
        check("t2_overflow", 32'(overflow), 0);
        check("t2_done_once", 32'(done_cnt), 1);
        check("t2_done_after_empty", 32'(done_dirty), 0);

        // Overflow: 84 words into a 64-deep FIFO with no consumer
        new_test();
        out_ready = 1'b0;
        start_job(1'b0, 8'h02, 8'h04, 10'd2);
        step();
        for (int i = 0; i < 84; i++) send(i);
        step();
        check("t3_overflow", 32'(overflow), 1);
        check("t3_words", 32'(words_rcvd), 84);
        check("t3_no_done_yet", 32'(done_cnt), 0);
        out_ready = 1'b1;
        wait_done(200);
        check_order("t3", 64);
        check("t3_done_once", 32'(done_cnt), 1);

        // Skipped index then watchdog abort
        new_test();
        out_ready = 1'b1;
        start_job(1'b0, 8'h01, 8'h01, 10'd1);
        step();
        send(0);
        send(1);
        check("t4_seq_before", 32'(seq_err), 0);
        send(3);
        check("t4_seq_err", 32'(seq_err), 1);
        check("t4_words", 32'(words_rcvd), 2);
        repeat (1000) step();
        check("t4_no_timeout_yet", {30'd0, timeout, busy}, 32'd1);
        wait_done(200);
        check("t4_timeout", 32'(timeout), 1);
        check("t4_done_once", 32'(done_cnt), 1);
        check_order("t4", 2);

        // Zero squeeze: no init, done two cycles after start
        new_test();
        begin
            int init_before;
            init_before = init_cnt;
            start_job(1'b1, 8'h05, 8'h06, 10'd0);
            check("t5_busy", 32'(busy), 1);
            check("t5_no_done_early", 32'(done), 0);
            step();
            check("t5_done", 32'(done), 1);
            step();
            check("t5_idle", {30'd0, done, busy}, 0);
            check("t5_no_init", 32'(init_cnt - init_before), 0);
            check("t5_cfg_kept", {22'd0, shk_mode, 1'b0, shk_absorb_num}, {22'd0, 1'b1, 1'b0, 8'h05});
        end

        // Reset mid-job after 10 captured words
        new_test();
        out_ready = 1'b0;
        start_job(1'b1, 8'h09, 8'h0A, 10'd3);
        step();
        for (int i = 0; i < 10; i++) send(i);
        check("t6_words_pre", 32'(words_rcvd), 10);
        rst = 1'b1;
        step();
        check("t6_busy", 32'(busy), 0);
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_words", 32'(words_rcvd), 0);
        check("t6_cfg", {22'd0, shk_mode, 1'b0, shk_absorb_num}, 0);
        rst = 1'b0;
        repeat (5) step();
        check("t6_no_done", 32'(done_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end

endmodule
